// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the RV32I instruction fetch front end:
// fetch FSM state encoding, the JALR opcode and the canonical NOP word.
package instr_fetch_unit_pkg;

    localparam logic [6:0]  OP_JALR        = 7'b1100111;
    localparam logic [31:0] NOP_INSTR_WORD = 32'h0000_0013;

    typedef enum logic [2:0] {
        IF_IDLE      = 3'd0,
        IF_REQ       = 3'd1,
        IF_ISSUE     = 3'd2,
        IF_JALR_WAIT = 3'd3,
        IF_DISCARD   = 3'd4
    } fetch_state_e;

    // Instruction addresses are word aligned; low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_field_split.sv
// Combinational split of an RV32I instruction word into the fields the
// control unit decodes. Shared by the fetch unit and the decode path.
module instr_field_split (
    input  logic [31:0] ir,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic        funct7
);

    // Bits outside the decoded fields are not needed by the control unit.
    logic unused_ir_bits;
    assign unused_ir_bits = ^{ir[31], ir[29:25]};

    // Plain bit slicing of the instruction word.
    always_comb begin
        opcode = ir[6:0];
        rd     = ir[11:7];
        funct3 = ir[14:12];
        rs1    = ir[19:15];
        rs2    = ir[24:20];
        funct7 = ir[30];
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding fetch at a time into the IR,
// stall-aware handoff to decode, JALR target wait and PC redirects.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013,
    parameter bit          JALR_WAIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,        // asynchronous, active low
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [6:0]  opcode_out,
    output logic [4:0]  rd_out,
    output logic [2:0]  funct3_out,
    output logic [4:0]  rs1_out,
    output logic [4:0]  rs2_out,
    output logic        funct7_out,
    output logic        misalign
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ir_q, ir_d;
    logic [31:0]  pc_out_q, pc_out_d;
    logic         instr_valid_q, instr_valid_d;
    logic         misalign_q, misalign_d;
    // Address of the request still in flight while its response is being
    // discarded; pc already points at the redirect target by then.
    logic [31:0]  disc_addr_q, disc_addr_d;

    instr_field_split u_field_split (
        .ir     (ir_q),
        .opcode (opcode_out),
        .rd     (rd_out),
        .funct3 (funct3_out),
        .rs1    (rs1_out),
        .rs2    (rs2_out),
        .funct7 (funct7_out)
    );

    // Next-state logic: redirect overrides every other event.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        pc_out_d      = pc_out_q;
        instr_valid_d = instr_valid_q;
        misalign_d    = 1'b0;
        disc_addr_d   = disc_addr_q;

        if (redirect) begin
            pc_d          = word_align(redirect_pc);
            ir_d          = NOP_INSTR;
            instr_valid_d = 1'b0;
            misalign_d    = |redirect_pc[1:0];
            case (state_q)
                IF_REQ: begin
                    // A sent request cannot be cancelled: if its response has
                    // not arrived yet, swallow it before refetching.
                    if (imem_valid) begin
                        state_d = IF_REQ;
                    end else begin
                        state_d     = IF_DISCARD;
                        disc_addr_d = pc_q;
                    end
                end
                IF_DISCARD: state_d = imem_valid ? IF_REQ : IF_DISCARD;
                default:    state_d = IF_REQ;
            endcase
        end else begin
            case (state_q)
                IF_IDLE: state_d = IF_REQ;
                IF_REQ: begin
                    if (imem_valid) begin
                        ir_d          = imem_rdata;
                        pc_out_d      = pc_q;
                        pc_d          = pc_q + 32'd4;
                        instr_valid_d = 1'b1;
                        state_d       = IF_ISSUE;
                    end
                end
                IF_ISSUE: begin
                    if (!stall) begin
                        ir_d          = NOP_INSTR;
                        instr_valid_d = 1'b0;
                        if (JALR_WAIT_EN && (opcode_out == OP_JALR)) begin
                            state_d = IF_JALR_WAIT;
                        end else begin
                            state_d = IF_REQ;
                        end
                    end
                end
                IF_JALR_WAIT: state_d = IF_JALR_WAIT;
                IF_DISCARD:   state_d = imem_valid ? IF_REQ : IF_DISCARD;
                default:      state_d = IF_IDLE;
            endcase
        end
    end

    // Fetch state and datapath registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IF_IDLE;
            pc_q          <= RESET_PC;
            ir_q          <= NOP_INSTR;
            pc_out_q      <= 32'h0000_0000;
            instr_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
            disc_addr_q   <= RESET_PC;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            pc_out_q      <= pc_out_d;
            instr_valid_q <= instr_valid_d;
            misalign_q    <= misalign_d;
            disc_addr_q   <= disc_addr_d;
        end
    end

    // Memory request is a pure decode of the state register.
    always_comb begin
        imem_req  = (state_q == IF_REQ) || (state_q == IF_DISCARD);
        imem_addr = (state_q == IF_DISCARD) ? disc_addr_q : pc_q;
    end

    assign instr_valid = instr_valid_q;
    assign instr_out   = ir_q;
    assign pc_out      = pc_out_q;
    assign misalign    = misalign_q;

endmodule
